eth_frame_writer: RTL

Multi-byte successor to the single-byte HLS write function. On a start pulse it issues one Ethernet header beat, then streams a payload of `len` bytes from a synchronous-read byte buffer onto the 8-bit AXI-stream payload interface of the eth_axis_tx-style framer. The last byte carries tlast, and the block pulses `done`. It sits between packet-building logic (which fills the buffer) and the Ethernet TX framer.

---
 rtl/eth_frame_writer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/eth_frame_writer.sv
// rtl/eth_frame_writer.sv - one Ethernet header beat, then len buffered payload bytes onto an 8-bit stream
// Optional feature macro: ETH_MIN_PAD_EN (zero-pad short payloads up to 46 bytes)
module eth_frame_writer #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [47:0]       dest_mac,
  input  logic [47:0]       src_mac,
  input  logic [15:0]       eth_type,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              m_eth_hdr_valid,
  input  logic              m_eth_hdr_ready,
  output logic [47:0]       m_eth_dest_mac,
  output logic [47:0]       m_eth_src_mac,
  output logic [15:0]       m_eth_type,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_SEND, S_FIN} state_t;
  state_t r_state, w_next;

  logic [LEN_W-1:0]  r_len, r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [7:0]        r_tdata;
  logic              r_hold;
  logic [47:0]       r_dest_mac, r_src_mac;
  logic [15:0]       r_eth_type;

  logic [LEN_W-1:0]  w_total, w_idx_inc;
  logic              w_pad, w_last, w_beat;

`ifdef ETH_MIN_PAD_EN
  localparam logic [LEN_W-1:0] MIN_PAYLOAD = LEN_W'(46);
  assign w_total = (r_len < MIN_PAYLOAD) ? MIN_PAYLOAD : r_len;
  assign w_pad   = (r_idx >= r_len);
`else
  assign w_total = r_len;
  assign w_pad   = 1'b0;
`endif

  assign w_idx_inc = r_idx + 1'b1;
  assign w_last    = (r_idx == w_total - 1'b1);
  assign w_beat    = (r_state == S_SEND) && m_axis_tready;

  assign m_eth_dest_mac = r_dest_mac;
  assign m_eth_src_mac  = r_src_mac;
  assign m_eth_type     = r_eth_type;
  assign m_axis_tuser   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    busy            = (r_state != S_IDLE);
    done            = 1'b0;
    m_eth_hdr_valid = 1'b0;
    m_axis_tvalid   = 1'b0;
    m_axis_tlast    = 1'b0;
    m_axis_tdata    = 8'h00;
    mem_raddr       = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == '0) ? S_FIN : S_HDR;
      end
      S_HDR: begin
        m_eth_hdr_valid = 1'b1;
        if (m_eth_hdr_ready) w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_raddr = r_base + r_idx[ADDR_W-1:0];
        w_next    = S_SEND;
      end
      S_SEND: begin
        // First SEND cycle forwards the fresh read; later stall cycles replay the captured byte.
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = w_last;
        if (!w_pad) m_axis_tdata = r_hold ? r_tdata : mem_rdata;
        if (m_axis_tready) begin
          if (w_last)                 w_next = S_FIN;
          else if (w_idx_inc < r_len) w_next = S_FETCH;
          else                        w_next = S_SEND;
        end
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_base     <= '0;
      r_tdata    <= '0;
      r_hold     <= 1'b0;
      r_dest_mac <= '0;
      r_src_mac  <= '0;
      r_eth_type <= '0;
    end else begin
      if (r_state == S_IDLE && start && len != '0) begin
        r_len      <= len;
        r_base     <= base_addr;
        r_idx      <= '0;
        r_hold     <= 1'b0;
        r_dest_mac <= dest_mac;
        r_src_mac  <= src_mac;
        r_eth_type <= eth_type;
      end
      if (r_state == S_FETCH) r_hold <= 1'b0;
      if (r_state == S_SEND && !r_hold && !w_pad) begin
        r_tdata <= mem_rdata;
        r_hold  <= 1'b1;
      end
      if (w_beat) begin
        r_hold <= 1'b0;
        r_idx  <= w_last ? '0 : w_idx_inc;
      end
    end
  end

endmodule
